biu_mux: RTL and testbench

BIU_MUX -- requirements
Module: biu_mux

---
 rtl/biu_pkg.sv | 18 +
 rtl/biu_decode.sv | 26 ++
 rtl/biu_mux.sv | 179 +++++++++++++++++
 tb/tb_biu_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// rtl/biu_pkg.sv - shared state encoding and default memory map for the bus interface mux
package biu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int IDX_W       = 3;
  localparam int WAIT_W      = 8;
  localparam int DEF_NSLV    = 3;
  localparam int DEF_TIMEOUT = 16;

  localparam logic [95:0] DEF_SLV_BASE = {32'h00800000, 32'h00400000, 32'h00000000};
  localparam logic [95:0] DEF_SLV_MASK = {32'hFFFFFFF8, 32'hFFFFFFE0, 32'hFFC00000};

endpackage

// File: rtl/biu_decode.sv
// rtl/biu_decode.sv - combinational address decode, lowest matching slave index wins
module biu_decode
  import biu_pkg::*;
#(
  parameter int                 NSLV     = DEF_NSLV,
  parameter logic [32*NSLV-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [32*NSLV-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic [31:0]      daddr,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  // Walk from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((daddr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/biu_mux.sv
// rtl/biu_mux.sv - routes one CPU access to a decoded slave, with wait timeout and bus-error reporting
module biu_mux
  import biu_pkg::*;
#(
  parameter int                 NSLV     = DEF_NSLV,
  parameter logic [32*NSLV-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [32*NSLV-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int                 TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          daddr,
  input  logic [31:0]          dwdata,
  input  logic [3:0]           dwe,
  input  logic                 dre,
  output logic [31:0]          drdata,
  output logic                 dready,
  output logic                 berr,
  output logic [15:0]          err_count,
  output logic [31:0]          s_daddr,
  output logic [31:0]          s_dwdata,
  output logic [4*NSLV-1:0]    s_dwe,
  output logic [NSLV-1:0]      s_dre,
  input  logic [32*NSLV-1:0]   s_drdata,
  input  logic [NSLV-1:0]      s_ready
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [31:0]         drdata_q, drdata_d;
  logic                dready_q, dready_d;
  logic                berr_q, berr_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4*NSLV-1:0]   s_dwe_q, s_dwe_d;
  logic [NSLV-1:0]     s_dre_q, s_dre_d;
  logic                rd_q, rd_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                req;
  logic                sel_ready;
  logic [31:0]         sel_rdata;

  biu_decode #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .daddr (daddr),
    .hit   (dec_hit),
    .index (dec_idx)
  );

  assign req = (dwe != 4'h0) | dre;

  // Only the latched slave's ready/data are visible; everyone else is ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_drdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drdata_d    = drdata_q;
    dready_d    = 1'b0;
    berr_d      = 1'b0;
    err_count_d = err_count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    s_dwe_d     = s_dwe_q;
    s_dre_d     = s_dre_q;
    rd_d        = rd_q;
    sel_d       = sel_q;
    wait_d      = wait_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (dec_hit) begin
            addr_d  = daddr;
            wdata_d = dwdata;
            rd_d    = dre;
            sel_d   = dec_idx;
            wait_d  = '0;
            for (int i = 0; i < NSLV; i++) begin
              s_dwe_d[4*i +: 4] = (dec_idx == IDX_W'(i)) ? dwe : 4'h0;
              s_dre_d[i]        = (dec_idx == IDX_W'(i)) && dre;
            end
            state_d = ST_ACCESS;
          end else begin
            drdata_d = 32'h0;
            dready_d = 1'b1;
            berr_d   = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end

      ST_ACCESS: begin
        // Ready on the expiry cycle still wins over the timeout.
        if (sel_ready) begin
          drdata_d = rd_q ? sel_rdata : 32'h0;
          dready_d = 1'b1;
          s_dwe_d  = '0;
          s_dre_d  = '0;
          state_d  = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          drdata_d = 32'h0;
          dready_d = 1'b1;
          berr_d   = 1'b1;
          s_dwe_d  = '0;
          s_dre_d  = '0;
          state_d  = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (berr_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drdata_q    <= 32'h0;
      dready_q    <= 1'b0;
      berr_q      <= 1'b0;
      err_count_q <= 16'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      s_dwe_q     <= '0;
      s_dre_q     <= '0;
      rd_q        <= 1'b0;
      sel_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      drdata_q    <= drdata_d;
      dready_q    <= dready_d;
      berr_q      <= berr_d;
      err_count_q <= err_count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      s_dwe_q     <= s_dwe_d;
      s_dre_q     <= s_dre_d;
      rd_q        <= rd_d;
      sel_q       <= sel_d;
      wait_q      <= wait_d;
    end
  end

  assign drdata    = drdata_q;
  assign dready    = dready_q;
  assign berr      = berr_q;
  assign err_count = err_count_q;
  assign s_daddr   = addr_q;
  assign s_dwdata  = wdata_q;
  assign s_dwe     = s_dwe_q;
  assign s_dre     = s_dre_q;

endmodule

// File: tb/tb_biu_mux.sv
// tb/tb_biu_mux.sv - directed and random accesses against a transaction-level reference model
module tb_biu_mux;

  localparam int TO = 16;
  localparam logic [31:0] M_BASE [3] = '{32'h00000000, 32'h00400000, 32'h00800000};
  localparam logic [31:0] M_MASK [3] = '{32'hFFC00000, 32'hFFFFFFE0, 32'hFFFFFFF8};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dwe;
  logic        dre;
  logic [31:0] drdata;
  logic        dready, berr;
  logic [15:0] err_count;
  logic [31:0] s_daddr, s_dwdata;
  logic [11:0] s_dwe;
  logic [2:0]  s_dre;
  logic [95:0] s_drdata;
  logic [2:0]  s_ready;

  logic [31:0] o_drdata, o_s_daddr, o_s_dwdata;
  logic        o_dready, o_berr;
  logic [15:0] o_err_count;
  logic [11:0] o_s_dwe;
  logic [2:0]  o_s_dre;

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  biu_mux #(.NSLV(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .dre(dre),
    .drdata(drdata), .dready(dready), .berr(berr), .err_count(err_count),
    .s_daddr(s_daddr), .s_dwdata(s_dwdata), .s_dwe(s_dwe), .s_dre(s_dre),
    .s_drdata(s_drdata), .s_ready(s_ready)
  );

  // Slaves 0 and 1 both claim the bottom 64 KiB here.
  biu_mux #(
    .NSLV(3), .TIMEOUT(TO),
    .SLV_BASE({32'h00800000, 32'h00000000, 32'h00000000}),
    .SLV_MASK({32'hFFFFFFF8, 32'hFFFF0000, 32'hFFC00000})
  ) dut_ovl (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .dre(dre),
    .drdata(o_drdata), .dready(o_dready), .berr(o_berr), .err_count(o_err_count),
    .s_daddr(o_s_daddr), .s_dwdata(o_s_dwdata), .s_dwe(o_s_dwe), .s_dre(o_s_dre),
    .s_drdata(s_drdata), .s_ready(s_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++) begin
      if ((a & M_MASK[i]) == M_BASE[i]) return i;
    end
    return -1;
  endfunction

  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] we, input logic rd, input int waits,
                         input logic [31:0] rdata, input bit chk_ovl);
    int          tgt, exp_lat, lat, scnt, acc_cycles, bad;
    logic        exp_berr, obs_berr, on;
    logic [31:0] exp_rd, obs_rd;
    logic [3:0]  ewe;
    tgt = model_decode(a);
    if (tgt < 0) begin
      exp_lat = 1; exp_berr = 1'b1; exp_rd = 32'h0;
    end else if (waits <= TO - 1) begin
      exp_lat = waits + 2; exp_berr = 1'b0; exp_rd = rd ? rdata : 32'h0;
    end else begin
      exp_lat = TO + 1; exp_berr = 1'b1; exp_rd = 32'h0;
    end
    if (exp_berr) exp_err++;

    @(negedge clk);
    daddr = a; dwdata = wd; dwe = we; dre = rd;
    lat = 0; scnt = 0; acc_cycles = 0; bad = 0;
    obs_berr = 1'b0; obs_rd = 32'h0;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        on  = (j == tgt) && (cyc < exp_lat);
        ewe = on ? we : 4'h0;
        if (s_dwe[4*j +: 4] !== ewe || s_dre[j] !== (on & rd)) bad++;
      end
      if (tgt >= 0 && (s_dre[tgt] || s_dwe[4*tgt +: 4] != 4'h0)) begin
        acc_cycles++;
        if (s_daddr !== a || s_dwdata !== wd) bad++;
      end
      if (chk_ovl && cyc == 1) begin
        check({tag, "_ovl_dwe"}, 64'(o_s_dwe), 64'({8'h00, we}));
        check({tag, "_ovl_dre"}, 64'(o_s_dre), 64'({2'b00, rd}));
        check({tag, "_ovl_addr"}, 64'({o_s_daddr, o_s_dwdata}), {a, wd});
      end
      if (dready === 1'b1) begin
        lat = cyc; obs_berr = berr; obs_rd = drdata;
        if (chk_ovl) check({tag, "_ovl_done"}, 64'({o_dready, o_berr, o_drdata}), 64'({1'b1, 1'b0, exp_rd}));
        dwe = 4'h0; dre = 1'b0;
      end
      // Slave model: noise on every unselected ready, target answers after 'waits' strobed cycles.
      s_ready  = 3'($urandom);
      s_drdata = {$urandom, $urandom, $urandom};
      if (tgt >= 0) begin
        s_ready[tgt] = 1'b0;
        if (s_dre[tgt] || s_dwe[4*tgt +: 4] != 4'h0) begin
          if (scnt == waits) begin
            s_ready[tgt] = 1'b1;
            s_drdata[32*tgt +: 32] = rdata;
          end
          scnt++;
        end
      end
    end
    dwe = 4'h0; dre = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_berr"}, 64'(obs_berr), 64'(exp_berr));
    check({tag, "_drdata"}, 64'(obs_rd), 64'(exp_rd));
    check({tag, "_strobes"}, 64'(bad), 64'd0);
    check({tag, "_acc_cycles"}, 64'(acc_cycles), 64'(tgt >= 0 ? exp_lat - 1 : 0));
    @(posedge clk); #1;
    s_ready = 3'b000;
    check({tag, "_pulse"}, 64'(dready), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        rd;
    logic [3:0]  we;
    int          pulses;

    reset = 1'b1; daddr = 32'h0; dwdata = 32'h0; dwe = 4'h0; dre = 1'b0;
    s_ready = 3'b000; s_drdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 64'({dready, berr, drdata, err_count}), 64'd0);
    check("rst_strobes", 64'({s_dwe, s_dre}), 64'd0);
    check("rst_latched", 64'({s_daddr, s_dwdata}), 64'd0);
    @(negedge clk); reset = 1'b0;

    run_txn("w_s0",   32'h00000010, 32'h12345678, 4'hF, 1'b0, 0,    32'h0,        1'b1);
    run_txn("r_s1",   32'h00400004, 32'h0,        4'h0, 1'b1, 3,    32'hCAFEF00D, 1'b0);
    run_txn("r_miss", 32'h00C00000, 32'h0,        4'h0, 1'b1, 0,    32'hDEADBEEF, 1'b0);
    run_txn("r_to",   32'h00800000, 32'h0,        4'h0, 1'b1, 1000, 32'h0,        1'b0);
    run_txn("r_edge", 32'h00800004, 32'h0,        4'h0, 1'b1, TO-1, 32'hA5A55A5A, 1'b0);
    run_txn("r_late", 32'h00800000, 32'h0,        4'h0, 1'b1, TO,   32'h13572468, 1'b0);
    run_txn("w_miss", 32'h00400020, 32'hFFFF0000, 4'h3, 1'b0, 0,    32'h0,        1'b0);
    run_txn("r_ovl",  32'h00000000, 32'h0,        4'h0, 1'b1, 1,    32'h11112222, 1'b1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom & 32'h003FFFFF;
        1:       a = 32'h00400000 | ($urandom & 32'h1F);
        2:       a = 32'h00800000 | ($urandom & 32'h7);
        default: a = 32'h00C00000 | ($urandom & 32'h003FFFFF);
      endcase
      rd = 1'($urandom_range(0, 1));
      we = rd ? 4'h0 : 4'($urandom_range(1, 15));
      run_txn($sformatf("rnd%0d", n), a, $urandom, we, rd, $urandom_range(0, 20), $urandom, 1'b0);
    end

    // Reset in the middle of an access must drop strobes without a completion.
    @(negedge clk);
    daddr = 32'h00800000; dre = 1'b1; dwe = 4'h0; s_ready = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_access", 64'(s_dre), 64'h4);
    @(negedge clk); reset = 1'b1; dre = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_strobes", 64'({s_dwe, s_dre}), 64'd0);
    check("rst_mid_outputs", 64'({dready, berr, err_count}), 64'd0);
    @(negedge clk); reset = 1'b0; exp_err = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (dready === 1'b1) pulses++;
    end
    check("rst_mid_no_dready", 64'(pulses), 64'd0);
    run_txn("post_rst", 32'h00400010, 32'h0, 4'h0, 1'b1, 2, 32'h0BADF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
